// File: rtl/fetch_unit.sv
// Instruction fetch front-end: single-outstanding memory requests into a prefetch queue,
// decoder handoff over valid/ready, branch redirect flush, and vectored interrupt entry.
module fetch_unit #(
    parameter int unsigned       WORD_W     = 12,
    parameter int unsigned       ADDR_W     = 2 * WORD_W,
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       NUM_IRQ    = 24,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'('h000100),
    parameter int unsigned       VEC_STRIDE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [WORD_W-1:0]          mem_rdata,
    output logic                       instr_valid,
    output logic [WORD_W-1:0]          instr_data,
    output logic [ADDR_W-1:0]          instr_addr,
    input  logic                       instr_ready,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic [NUM_IRQ-1:0]         irq_mask,
    input  logic                       irq_enable,
    input  logic                       irq_return,
    output logic                       irq_taken,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    output logic [ADDR_W-1:0]          epc,
    output logic                       in_irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ID_W  = $clog2(NUM_IRQ);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_cons_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [PTR_W:0]    r_count;
    logic              r_outstanding;
    logic              r_discard;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [WORD_W-1:0] r_q_data [DEPTH];
    logic [ADDR_W-1:0] r_q_addr [DEPTH];

    logic              r_in_irq;
    logic              r_irq_taken;
    logic [ID_W-1:0]   r_irq_id;
    logic [ADDR_W-1:0] r_epc;

    logic              w_mem_req;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [NUM_IRQ-1:0] w_irq_pend;
    logic [ID_W-1:0]   w_irq_id;
    logic              w_take;
    logic              w_flush;
    logic [ADDR_W-1:0] w_vec_addr;
    logic [ADDR_W-1:0] w_target;

    // A presented request stays up with its original address until acked, even across a
    // flush; r_outstanding marks that hold so a stale address is never swapped mid-request.
    assign w_mem_req  = ~rst & (r_outstanding | (r_count < FULL_CNT));
    assign w_mem_addr = r_outstanding ? r_req_addr : r_fetch_pc;
    assign w_accept   = w_mem_req & mem_ack;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & instr_ready;

    assign w_irq_pend = irq & irq_mask;

    always_comb begin
        w_irq_id = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (w_irq_pend[i-1]) w_irq_id = ID_W'(i - 1);
        end
    end

    assign w_take     = irq_enable & ~r_in_irq & ~redirect_valid & (|w_irq_pend);
    assign w_flush    = redirect_valid | w_take;
    assign w_vec_addr = VEC_BASE + ADDR_W'(w_irq_id) * ADDR_W'(VEC_STRIDE);
    assign w_target   = redirect_valid ? redirect_addr : w_vec_addr;
    assign w_push     = w_accept & ~r_discard & ~w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_ADDR;
            r_cons_pc     <= RESET_ADDR;
            r_req_addr    <= RESET_ADDR;
            r_count       <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_addr[i] <= '0;
            end
        end else begin
            r_outstanding <= w_mem_req & ~mem_ack;
            if (w_mem_req & ~mem_ack) r_req_addr <= w_mem_addr;

            if (w_accept) begin
                r_discard <= 1'b0;
            end else if (w_flush & w_mem_req) begin
                r_discard <= 1'b1;
            end

            if (w_flush) begin
                r_fetch_pc <= w_target;
            end else if (w_accept & ~r_discard) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end

            if (w_flush) begin
                r_cons_pc <= w_target;
            end else if (w_pop) begin
                r_cons_pc <= r_cons_pc + 1'b1;
            end

            if (w_flush) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (w_push) begin
                    r_q_data[r_tail] <= mem_rdata;
                    r_q_addr[r_tail] <= w_mem_addr;
                    r_tail           <= r_tail + 1'b1;
                end
                if (w_pop) r_head <= r_head + 1'b1;
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_irq    <= 1'b0;
            r_irq_taken <= 1'b0;
            r_irq_id    <= '0;
            r_epc       <= '0;
        end else begin
            r_irq_taken <= w_take;
            if (w_take) begin
                r_in_irq <= 1'b1;
                r_irq_id <= w_irq_id;
                // A word handed to the decoder this cycle has already retired from fetch.
                r_epc    <= w_pop ? r_cons_pc + 1'b1 : r_cons_pc;
            end else if (irq_return) begin
                r_in_irq <= 1'b0;
            end
        end
    end

    assign mem_req     = w_mem_req;
    assign mem_addr    = w_mem_addr;
    assign instr_valid = w_valid;
    assign instr_data  = r_q_data[r_head];
    assign instr_addr  = r_q_addr[r_head];
    assign irq_taken   = r_irq_taken;
    assign irq_id      = r_irq_id;
    assign epc         = r_epc;
    assign in_irq      = r_in_irq;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural memory with programmable ack latency
// and a scoreboard of program-order (addr, data) words expected at the decoder.
module tb_fetch_unit;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned NIRQ   = 24;

    logic              clk;
    logic              rst;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [WORD_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [NIRQ-1:0]   irq;
    logic [NIRQ-1:0]   irq_mask;
    logic              irq_enable;
    logic              irq_return;
    logic              irq_taken;
    logic [4:0]        irq_id;
    logic [ADDR_W-1:0] epc;
    logic              in_irq;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int ack_total = 0;

    logic [35:0] exp_q [$];

    // memory model controls
    logic        stall;
    logic        force_ack;
    int unsigned ack_delay;
    int unsigned hold;
    logic        m_prev_req;
    logic        m_prev_ack;

    // address-stability monitor state
    logic              prev_req;
    logic              prev_ack;
    logic [ADDR_W-1:0] prev_addr;

    fetch_unit #(
        .WORD_W(12), .ADDR_W(24), .DEPTH(4), .NUM_IRQ(24),
        .RESET_ADDR(24'h000000), .VEC_BASE(24'h000100), .VEC_STRIDE(4)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .irq(irq), .irq_mask(irq_mask), .irq_enable(irq_enable), .irq_return(irq_return),
        .irq_taken(irq_taken), .irq_id(irq_id), .epc(epc), .in_irq(in_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: word at address a is a[11:0] + 'h100; ack after ack_delay waiting cycles
    always @(posedge clk) begin
        #2;
        if (m_prev_req && !m_prev_ack && mem_req) hold = hold + 1;
        else hold = 0;
        mem_ack   = force_ack | (mem_req & ~stall & (hold >= ack_delay));
        mem_rdata = mem_addr[11:0] + 12'h100;
        m_prev_req = mem_req;
        m_prev_ack = mem_ack;
    end

    function automatic logic [35:0] word_of(input logic [ADDR_W-1:0] a);
        logic [11:0] d;
        d = a[11:0] + 12'h100;
        return {a, d};
    endfunction

    task automatic expect_word(input logic [ADDR_W-1:0] a);
        exp_q.push_back(word_of(a));
    endtask

    // advance one cycle; at mid-cycle pop/compare the scoreboard and watch mem_addr holding
    task automatic cyc();
        logic [35:0] e;
        @(negedge clk);
        if (!rst && instr_valid && instr_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got addr=%h data=%h required none", instr_addr, instr_data);
            end else begin
                e = exp_q.pop_front();
                if ({instr_addr, instr_data} !== e) begin
                    failures++;
                    $display("FAIL sb_word got addr=%h data=%h required addr=%h data=%h",
                             instr_addr, instr_data, e[35:12], e[11:0]);
                end
            end
        end
        if (mem_req === 1'b1 && mem_ack === 1'b1) ack_total++;
        if (!rst && prev_req && !prev_ack && mem_req) begin
            checks++;
            if (mem_addr !== prev_addr) begin
                failures++;
                $display("FAIL mem_addr_hold got=%h required=%h", mem_addr, prev_addr);
            end
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
    endtask

    task automatic redirect_to(input logic [ADDR_W-1:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b required=0", mem_req); end
        checks++; if (mem_addr !== 24'h0) begin failures++; $display("FAIL rst_mem_addr got=%h required=0", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got=%b required=0", instr_valid); end
        checks++; if (instr_data !== 12'h0 || instr_addr !== 24'h0) begin failures++; $display("FAIL rst_head got=%h/%h required=0/0", instr_addr, instr_data); end
        checks++; if (irq_taken !== 1'b0 || in_irq !== 1'b0) begin failures++; $display("FAIL rst_irq_flags got=%b%b required=00", irq_taken, in_irq); end
        checks++; if (irq_id !== 5'd0 || epc !== 24'h0) begin failures++; $display("FAIL rst_irq_regs got id=%0d epc=%h required 0/0", irq_id, epc); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) expect_word(24'(i));
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h0) begin failures++; $display("FAIL first_req got req=%b addr=%h required 1/0", mem_req, mem_addr); end
        for (int i = 0; i < 9; i++) cyc();
        checks++; if (pops !== 8) begin failures++; $display("FAIL stream_rate got=%0d required=8", pops); end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1) break;
            cyc();
        end
        for (int i = 0; i < 3; i++) cyc();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%b required=0", mem_req); end
        checks++; if (ack_total !== 12) begin failures++; $display("FAIL full_acks got=%0d required=12", ack_total); end
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 24'h8 || instr_data !== 12'h108) begin failures++; $display("FAIL full_head got v=%b %h/%h required 1 000008/108", instr_valid, instr_addr, instr_data); end
        expect_word(24'd12);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'd12) begin failures++; $display("FAIL refill_req got req=%b addr=%h required 1/00000c", mem_req, mem_addr); end
        cyc();
        checks++; if (mem_req !== 1'b0 || ack_total !== 13) begin failures++; $display("FAIL refull got req=%b acks=%0d required 0/13", mem_req, ack_total); end
        stall = 1'b1;
        instr_ready = 1'b1;
        drain(20);
        instr_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_drain got=%0d required=0 left", exp_q.size()); end
    endtask

    task automatic test_redirect_inflight();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'd13) begin failures++; $display("FAIL pend_req got req=%b addr=%h required 1/00000d", mem_req, mem_addr); end
        ack_delay = 3;
        for (int i = 0; i < 4; i++) expect_word(24'h000500 + 24'(i));
        redirect_to(24'h000500);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b required=0", instr_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'd13) begin failures++; $display("FAIL stale_hold got req=%b addr=%h required 1/00000d", mem_req, mem_addr); end
        stall = 1'b0;
        cyc();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h000500) begin failures++; $display("FAIL redir_req got req=%b addr=%h required 1/000500", mem_req, mem_addr); end
        instr_ready = 1'b1;
        drain(40);
        instr_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL redir_drain got=%0d required=0 left", exp_q.size()); end
    endtask

    task automatic test_irq_vector();
        ack_delay = 0;
        expect_word(24'h000040);
        expect_word(24'h000041);
        redirect_to(24'h000040);
        instr_ready = 1'b1;
        drain(20);
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        irq = 24'h000030;
        irq_mask = '1;
        irq_enable = 1'b1;
        cyc();
        checks++; if (irq_taken !== 1'b1 || irq_id !== 5'd4) begin failures++; $display("FAIL take got taken=%b id=%0d required 1/4", irq_taken, irq_id); end
        checks++; if (epc !== 24'h000042 || in_irq !== 1'b1) begin failures++; $display("FAIL take_ctx got epc=%h in_irq=%b required 000042/1", epc, in_irq); end
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 24'h000110) begin failures++; $display("FAIL vec_req got v=%b req=%b addr=%h required 0/1/000110", instr_valid, mem_req, mem_addr); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (irq_taken !== 1'b0) begin failures++; $display("FAIL nested_take got=%b required=0", irq_taken); end
        end
        checks++; if (in_irq !== 1'b1 || epc !== 24'h000042 || irq_id !== 5'd4) begin failures++; $display("FAIL ctx_hold got in=%b epc=%h id=%0d required 1/000042/4", in_irq, epc, irq_id); end
        expect_word(24'h000110);
        expect_word(24'h000111);
        instr_ready = 1'b1;
        drain(20);
        instr_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL vec_drain got=%0d required=0 left", exp_q.size()); end
        irq_enable = 1'b0;
        irq_return = 1'b1;
        cyc();
        irq_return = 1'b0;
        checks++; if (in_irq !== 1'b0) begin failures++; $display("FAIL irq_return got=%b required=0", in_irq); end
    endtask

    task automatic test_simultaneous();
        irq = 24'h000001;
        irq_enable = 1'b1;
        redirect_to(24'h000700);
        checks++; if (irq_taken !== 1'b0 || in_irq !== 1'b0) begin failures++; $display("FAIL redir_wins got taken=%b in=%b required 0/0", irq_taken, in_irq); end
        cyc();
        checks++; if (irq_taken !== 1'b1 || irq_id !== 5'd0 || epc !== 24'h000700) begin failures++; $display("FAIL late_take got taken=%b id=%0d epc=%h required 1/0/000700", irq_taken, irq_id, epc); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h000100) begin failures++; $display("FAIL vec0_req got req=%b addr=%h required 1/000100", mem_req, mem_addr); end
        irq_enable = 1'b0;
        expect_word(24'h000100);
        expect_word(24'h000101);
        instr_ready = 1'b1;
        drain(20);
        instr_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL sim_drain got=%0d required=0 left", exp_q.size()); end
        irq_return = 1'b1;
        cyc();
        irq_return = 1'b0;
        irq = '0;
    endtask

    task automatic test_wrap();
        expect_word(24'hFFFFFE);
        expect_word(24'hFFFFFF);
        expect_word(24'h000000);
        redirect_to(24'hFFFFFE);
        instr_ready = 1'b1;
        drain(20);
        instr_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL wrap_drain got=%0d required=0 left", exp_q.size()); end
    endtask

    task automatic test_reset_midop();
        stall = 1'b1;
        redirect_to(24'h000300);
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b required=1", mem_req); end
        rst = 1'b1;
        force_ack = 1'b1;
        cyc();
        checks++; if (mem_req !== 1'b0 || mem_addr !== 24'h0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst got req=%b addr=%h v=%b required 0/0/0", mem_req, mem_addr, instr_valid); end
        checks++; if (epc !== 24'h0 || in_irq !== 1'b0 || irq_taken !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got epc=%h in=%b tk=%b required 0/0/0", epc, in_irq, irq_taken); end
        cyc();
        rst = 1'b0;
        force_ack = 1'b0;
        stall = 1'b0;
        expect_word(24'h0);
        expect_word(24'h1);
        expect_word(24'h2);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h0) begin failures++; $display("FAIL post_rst_req got req=%b addr=%h required 1/0", mem_req, mem_addr); end
        instr_ready = 1'b1;
        drain(20);
        instr_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL post_rst_drain got=%0d required=0 left", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        irq = '0;
        irq_mask = '0;
        irq_enable = 1'b0;
        irq_return = 1'b0;
        stall = 1'b0;
        force_ack = 1'b0;
        ack_delay = 0;
        hold = 0;
        m_prev_req = 1'b0;
        m_prev_ack = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_irq_vector();
        test_simultaneous();
        test_wrap();
        test_reset_midop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
